// File: rtl/abs32_rr_arbiter_if.sv
// Requester/response bundle for abs32_rr_arbiter. The ovf_count/ovf_clr pair
// is present only when ABS32_OVF_STATS_EN is defined.
interface abs32_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ovf;
  logic              busy;

`ifdef ABS32_OVF_STATS_EN
  logic [15:0]       ovf_count;
  logic              ovf_clr;

  modport master (
    output req_valid, req_data, rsp_ready, ovf_clr,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy, ovf_count
  );

  modport slave (
    input  req_valid, req_data, rsp_ready, ovf_clr,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy, ovf_count
  );
`else
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf, busy
  );
`endif
endinterface

// File: rtl/abs32_rr_arbiter.sv
// Round-robin shared absolute-value unit with a single registered response slot.
// Define ABS32_OVF_STATS_EN to add the saturating overflow counter (ovf_count/ovf_clr).
module abs32_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  abs32_rr_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  // Two's-complement magnitude; the most-negative value maps onto itself.
  function automatic logic [W-1:0] abs_f(input logic [W-1:0] x);
    return x[W-1] ? (~x + ONE_W) : x;
  endfunction

  function automatic logic is_min_neg_f(input logic [W-1:0] x);
    return (x == MIN_NEG);
  endfunction

  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q,  rsp_data_d;
  logic [IDW-1:0] rsp_id_q,    rsp_id_d;
  logic           rsp_ovf_q,   rsp_ovf_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic            slot_free_s;
  logic            grant_found_s;
  logic            accept_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [IDW-1:0]  cand_s;
  logic [W-1:0]    op_s;
  logic [NREQ-1:0] req_ready_s;

  assign slot_free_s = !rsp_valid_q || bus.rsp_ready;
  assign accept_s    = slot_free_s && grant_found_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((32'(last_grant_q) + 32'(k)) % 32'(NREQ));
      if (!grant_found_s && bus.req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand mux and one-hot accept strobes for the granted requester.
  always_comb begin
    op_s        = '0;
    req_ready_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == IDW'(i)) begin
        op_s           = bus.req_data[i*W +: W];
        req_ready_s[i] = accept_s;
      end else begin
        req_ready_s[i] = 1'b0;
      end
    end
  end

  // Response slot next state: a new accept replaces a draining result with no bubble.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_ovf_d    = rsp_ovf_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      rsp_valid_d  = 1'b1;
      rsp_data_d   = abs_f(op_s);
      rsp_id_d     = grant_idx_s;
      rsp_ovf_d    = is_min_neg_f(op_s);
      last_grant_d = grant_idx_s;
    end else if (bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end else begin
      rsp_valid_d  = rsp_valid_q;
    end
  end

  // Slot and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_ovf_q    <= 1'b0;
      last_grant_q <= LAST_IDX;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_ovf_q    <= rsp_ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef ABS32_OVF_STATS_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  // Saturating count of overflowed results actually delivered; clear has priority.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (bus.ovf_clr) begin
      ovf_count_d = 16'h0000;
    end else if (rsp_valid_q && bus.rsp_ready && rsp_ovf_q && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_d = ovf_count_q + 16'h0001;
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= 16'h0000;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign bus.ovf_count = ovf_count_q;
`endif

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = rsp_valid_q | (|bus.req_valid);
endmodule

// File: tb/tb_abs32_rr_arbiter.sv
// Directed self-checking bench for abs32_rr_arbiter (NREQ=4, W=32).
module tb_abs32_rr_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  abs32_rr_arbiter_if #(.NREQ(4), .W(32)) bus_if ();

  abs32_rr_arbiter #(.NREQ(4), .W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int idx, input logic [31:0] val);
    bus_if.req_data[idx*32 +: 32] = val;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] id, input logic ovf);
    chk({tag, ".valid"}, 64'(bus_if.rsp_valid), 64'(v));
    chk({tag, ".data"},  64'(bus_if.rsp_data),  64'(d));
    chk({tag, ".id"},    64'(bus_if.rsp_id),    64'(id));
    chk({tag, ".ovf"},   64'(bus_if.rsp_ovf),   64'(ovf));
  endtask

  initial begin
    logic [31:0] edge_in  [4];
    logic [31:0] edge_out [4];
    logic        edge_ovf [4];
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.req_valid = 4'b0000;
    bus_if.req_data  = '0;
    bus_if.rsp_ready = 1'b0;
`ifdef ABS32_OVF_STATS_EN
    bus_if.ovf_clr = 1'b0;
`endif
    #12;
    chk_rsp("reset", 1'b0, 32'h0, 2'd0, 1'b0);
    chk("reset.busy", 64'(bus_if.busy), 64'd0);
    chk("reset.ready", 64'(bus_if.req_ready), 64'h0);
    step();
    rst_n = 1'b1;
    step();

    // Single op from requester 0
    set_op(0, 32'hFFFF_FFF6);
    bus_if.req_valid = 4'b0001;
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("single.ready", 64'(bus_if.req_ready), 64'h1);
    chk("single.busy", 64'(bus_if.busy), 64'd1);
    step();
    chk_rsp("single", 1'b1, 32'h0000_000A, 2'd0, 1'b0);

    // Edge operands back to back through requester 0
    edge_in[0] = 32'h0000_0000; edge_out[0] = 32'h0000_0000; edge_ovf[0] = 1'b0;
    edge_in[1] = 32'h7FFF_FFFF; edge_out[1] = 32'h7FFF_FFFF; edge_ovf[1] = 1'b0;
    edge_in[2] = 32'h8000_0000; edge_out[2] = 32'h8000_0000; edge_ovf[2] = 1'b1;
    edge_in[3] = 32'h0000_0001; edge_out[3] = 32'h0000_0001; edge_ovf[3] = 1'b0;
    for (int e = 0; e < 4; e++) begin
      set_op(0, edge_in[e]);
      step();
      chk_rsp($sformatf("edge%0d", e), 1'b1, edge_out[e], 2'd0, edge_ovf[e]);
    end

    // Round robin: last grant is 0, so service order is 1,2,3,0,1,2,3,0
    for (int i = 0; i < 4; i++) set_op(i, 32'hFFFF_FFF0 - 32'(i));
    bus_if.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d.ready", k), 64'(bus_if.req_ready), 64'(4'b0001 << ((k + 1) % 4)));
      step();
      chk_rsp($sformatf("rr%0d", k), 1'b1, 32'h10 + 32'((k + 1) % 4), 2'((k + 1) % 4), 1'b0);
    end

    // Backpressure: result from req 0 (0x10) pending, req 2 waiting
    bus_if.req_valid = 4'b0100;
    set_op(2, 32'hFFFF_FF00);
    bus_if.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d.ready", k), 64'(bus_if.req_ready), 64'h0);
      step();
      chk_rsp($sformatf("bp%0d", k), 1'b1, 32'h0000_0010, 2'd0, 1'b0);
    end
    bus_if.rsp_ready = 1'b1;
    #1;
    chk("bp.release.ready", 64'(bus_if.req_ready), 64'h4);
    step();
    chk_rsp("bp.accept", 1'b1, 32'h0000_0100, 2'd2, 1'b0);
    bus_if.req_valid = 4'b0000;
    step();
    chk_rsp("drain", 1'b0, 32'h0000_0100, 2'd2, 1'b0);
    chk("drain.busy", 64'(bus_if.busy), 64'd0);

    // Reset while a result is pending
    set_op(1, 32'hFFFF_FFFF);
    bus_if.req_valid = 4'b0010;
    bus_if.rsp_ready = 1'b0;
    step();
    chk_rsp("pre_rst", 1'b1, 32'h0000_0001, 2'd1, 1'b0);
    bus_if.req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    chk_rsp("mid_rst", 1'b0, 32'h0, 2'd0, 1'b0);
    step();
    rst_n = 1'b1;
    bus_if.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post_rst%0d.valid", k), 64'(bus_if.rsp_valid), 64'd0);
    end
    // Pointer restored to NREQ-1: requester 0 wins over 3
    set_op(0, 32'h0000_0005);
    set_op(3, 32'hFFFF_FFFD);
    bus_if.req_valid = 4'b1001;
    #1;
    chk("post_rst.ready", 64'(bus_if.req_ready), 64'h1);
    step();
    chk_rsp("post_rst.op", 1'b1, 32'h0000_0005, 2'd0, 1'b0);
    #1;
    chk("post_rst.next", 64'(bus_if.req_ready), 64'h8);
    step();
    chk_rsp("post_rst.op3", 1'b1, 32'h0000_0003, 2'd3, 1'b0);
    bus_if.req_valid = 4'b0000;
    step();

`ifdef ABS32_OVF_STATS_EN
    chk("stats.init", 64'(bus_if.ovf_count), 64'd0);
    set_op(0, 32'h8000_0000);
    bus_if.req_valid = 4'b0001;
    step();
    step();
    step();
    bus_if.req_valid = 4'b0000;
    step();
    chk("stats.three", 64'(bus_if.ovf_count), 64'd3);
    bus_if.ovf_clr = 1'b1;
    step();
    bus_if.ovf_clr = 1'b0;
    chk("stats.clr", 64'(bus_if.ovf_count), 64'd0);
    force dut.ovf_count_q = 16'hFFFF;
    step();
    release dut.ovf_count_q;
    chk("stats.forced", 64'(bus_if.ovf_count), 64'hFFFF);
    bus_if.req_valid = 4'b0001;
    step();
    bus_if.req_valid = 4'b0000;
    step();
    chk("stats.sat", 64'(bus_if.ovf_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/abs32_rr_arbiter.md
Name: abs32_rr_arbiter

Overview:
- Shares one registered 32-bit absolute-value datapath (two's-complement negate-if-negative) between NREQ requesters.
- Each requester uses a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The selected operand is computed combinationally and captured in a single output slot, which is drained through a valid/ready response port tagged with the requester index.
- Sits between the FHE-benchmark compute clients and the shared abs unit.

Parameters:
- NREQ, 4: number of requesters; legal range 2..16.
- W, 32: operand and result width in bits.
- IDW, $clog2(NREQ): width of the requester-id tag (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_data  input  NREQ*W  operands; requester i occupies bits [i*W +: W].
- rsp_valid  output  1  output slot holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_data  output  W  |operand| mod 2^W.
- rsp_id  output  IDW  index of the requester that produced rsp_data.
- rsp_ovf  output  1  operand was the most-negative value (1 followed by W-1 zeros).
- busy  output  1  equals rsp_valid OR any req_valid bit.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0.
  - last_grant=NREQ-1, so requester 0 has top priority first.
  - Any in-flight result is discarded; no response is issued for it.
- slot_free = !rsp_valid | rsp_ready.
- Arbitration is combinational:
  - Search from (last_grant+1) mod NREQ upward, with wrap-around.
  - The first i with req_valid[i]=1 is the grant.
  - req_ready[i] = slot_free & grant[i]. req_ready may depend on req_valid within the same cycle.
  - Requesters must not depend on req_ready to assert req_valid.
- Accept: a transfer on cycle t occurs when req_valid[i] & req_ready[i]. At the edge:
  - rsp_valid=1, rsp_id=i, last_grant=i.
  - rsp_data = req_data[i][W-1] ? (~req_data[i] + 1) truncated to W : req_data[i].
  - rsp_ovf = (req_data[i] == {1'b1,{W-1{1'b0}}}). In this case rsp_data equals the operand unchanged.
- Latency: exactly 1 cycle from accept to rsp_valid.
  - Throughput: 1 op/cycle while rsp_ready=1.
- Drain with no accept: if rsp_valid & rsp_ready and there is no accept, rsp_valid goes 0 next cycle. rsp_data, rsp_id and rsp_ovf hold their last values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge. There is no bubble.
- Backpressure: while rsp_valid & !rsp_ready:
  - All req_ready=0.
  - The output slot holds stable.
  - last_grant is unchanged.
- Fairness: last_grant advances only on accept. A continuously valid requester is served within NREQ accepts.
- No other state; no FSM beyond the slot-full bit and the pointer.

Optional Feature:
- Macro: ABS32_OVF_STATS_EN.
- When defined:
  - Adds output ovf_count[15:0].
  - The counter increments on each response handshake (rsp_valid & rsp_ready) with rsp_ovf=1.
  - It saturates at 0xFFFF and resets to 0 on rst_n.
  - Also adds input ovf_clr, which clears the counter synchronously. If ovf_clr coincides with an increment, the clear wins.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset mid-op: accept 0xFFFFFFFF from req 1, assert rst_n=0 before drain -> rsp_valid=0 immediately; no response is ever seen for it.
- Single op: req 0 sends 0xFFFFFFF6 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x0000000A, rsp_id=0, rsp_ovf=0.
- Edge values: operands 0x00000000, 0x7FFFFFFF, 0x80000000, 0x00000001 -> results 0x00000000, 0x7FFFFFFF, 0x80000000 (rsp_ovf=1), 0x00000001.
- Round robin: all 4 requesters valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,... with one result per cycle and no gaps.
- Backpressure: hold rsp_ready=0 for 5 cycles with a result pending and req 2 valid -> req_ready=0, rsp_data/rsp_id stable. On release, the pending result drains and req 2 is accepted in the same cycle.
- With ABS32_OVF_STATS_EN: 3 handshakes of 0x80000000 then ovf_clr -> ovf_count reads 3, then 0. Forcing 0xFFFF plus another overflow -> stays 0xFFFF.
